// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential ROM fetch, small PC-tagged FIFO toward decode, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
//
// state    | meaning
// ST_RUN   | normal fetch; responses are written into the FIFO
// ST_FLUSH | cycle after a redirect; any arriving response is killed
module fetch_queue #(
  parameter int                ADDR_W   = 20,
  parameter int                DATA_W   = 20,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [ADDR_W-1:0]          rom_addr,
  output logic                       rom_req,
  input  logic [DATA_W-1:0]          rom_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [DATA_W-1:0]          instr_out,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [CW:0]       occupancy;
  logic              issue;
  logic              resp_ok;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              bypass_take;

  // Issue is conservative: a same-cycle pop never frees a slot for this cycle's request.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue      = rst_n & ~redirect & (occupancy < DEPTH_OCC);
  assign rom_req    = issue;
  assign rom_addr   = fetch_pc;
  assign fifo_count = count;
  assign fifo_empty = (count == '0);

  assign resp_ok = rst_n & inflight & ~redirect & (state != ST_FLUSH);
  assign pop     = ~fifo_empty & instr_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_take = resp_ok & fifo_empty & instr_ready;
  assign instr_valid = ~fifo_empty | resp_ok;
  assign instr_out   = fifo_empty ? rom_data    : mem_data[rd_ptr];
  assign instr_pc    = fifo_empty ? inflight_pc : mem_pc[rd_ptr];
`else
  assign bypass_take = 1'b0;
  assign instr_valid = ~fifo_empty;
  assign instr_out   = mem_data[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
`endif

  assign push = resp_ok & ~bypass_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      state    <= redirect ? ST_FLUSH : ST_RUN;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          mem_data[wr_ptr] <= rom_data;
          mem_pc[wr_ptr]   <= inflight_pc;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && !redirect)
      assert (!(push && count == DEPTH_CNT))
        else $error("fetch_queue: push into full FIFO");
  end

endmodule
